// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential RV M-extension multiply/divide unit.
//   Multiplies by shift-add and divides by restoring division, one bit per
//   clock for XLEN clocks (CALC). The sign fix-up and special-case overrides
//   are applied in one further cycle (FIX). done pulses for one cycle (DONE).
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   start  - request, sampled in IDLE/DONE only
//   op     - funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   a, b   - rs1 / rs2 operands, latched on an accepted start
//   busy   - high in CALC and FIX
//   done   - one-cycle result-valid pulse
//   result - held until the next operation's FIX cycle
// Build option: define MULDIV_EARLY_OUT_EN to skip CALC when the result is
//   known up front (divide by zero, signed overflow, multiply by zero).
module muldiv_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;

  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q;       // raw rs1, needed by the div-by-zero/overflow overrides
  logic [XLEN-1:0]   d_q;       // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] p_q;       // mul: {acc, multiplier}; div: {rem, quotient}
  logic [CW-1:0]     cnt_q;
  logic              neg_a_q, neg_b_q, bz_q, ovf_q, mz_q;

  // ---- operand decode at acceptance ----
  logic            accept, sgn_a, sgn_b, na, nb, bz_in, ovf_in, mz_in;
  logic [XLEN-1:0] am, bm;

  always_comb begin
    accept = start && (state_q == IDLE || state_q == DONE);
    sgn_a  = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    sgn_b  = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    na     = sgn_a && a[XLEN-1];
    nb     = sgn_b && b[XLEN-1];
    am     = na ? -a : a;
    bm     = nb ? -b : b;
    bz_in  = op[2] && (b == '0);
    ovf_in = op[2] && !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    mz_in  = !op[2] && ((a == '0) || (b == '0));
  end

  // ---- one iteration step ----
  logic [XLEN:0]     sum, trial;
  logic [2*XLEN:0]   sh;
  logic [2*XLEN-1:0] p_nx;

  always_comb begin
    sum   = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, d_q} : {(XLEN+1){1'b0}});
    sh    = {p_q, 1'b0};
    // Remainder stays below the divisor, so the shifted remainder fits in
    // XLEN+1 bits and its top bit is zero whenever the trial goes negative.
    trial = sh[2*XLEN:XLEN] - {1'b0, d_q};
    if (op_q[2])
      p_nx = trial[XLEN] ? sh[2*XLEN-1:0] : {trial[XLEN-1:0], sh[XLEN-1:1], 1'b1};
    else
      p_nx = {sum, p_q[XLEN-1:1]};
  end

  // ---- sign correction and overrides ----
  logic [2*XLEN-1:0] pf;
  logic [XLEN-1:0]   qf, rf, fix_res;

  always_comb begin
    pf = (neg_a_q ^ neg_b_q) ? -p_q : p_q;
    qf = (neg_a_q ^ neg_b_q) ? -p_q[XLEN-1:0] : p_q[XLEN-1:0];
    rf = neg_a_q ? -p_q[2*XLEN-1:XLEN] : p_q[2*XLEN-1:XLEN];
    if (!op_q[2])
      fix_res = mz_q ? '0 : ((op_q[1:0] == 2'b00) ? pf[XLEN-1:0] : pf[2*XLEN-1:XLEN]);
    else if (op_q[1])
      fix_res = bz_q ? a_q : (ovf_q ? '0 : rf);
    else
      fix_res = bz_q ? '1 : (ovf_q ? a_q : qf);
  end

  // ---- FSM ----
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
`ifdef MULDIV_EARLY_OUT_EN
          state_d = (op[2] ? (bz_in || ovf_in) : mz_in) ? FIX : CALC;
`else
          state_d = CALC;
`endif
        end
      end
      CALC:    if (cnt_q == CW'(XLEN - 1)) state_d = FIX;
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == CALC) || (state_q == FIX);
  assign done = (state_q == DONE);

  // ---- datapath ----
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      a_q     <= '0;
      d_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      bz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      mz_q    <= 1'b0;
      result  <= '0;
    end else if (accept) begin
      op_q    <= op;
      a_q     <= a;
      d_q     <= op[2] ? bm : am;
      p_q     <= {{XLEN{1'b0}}, (op[2] ? am : bm)};
      cnt_q   <= '0;
      neg_a_q <= na;
      neg_b_q <= nb;
      bz_q    <= bz_in;
      ovf_q   <= ovf_in;
      mz_q    <= mz_in;
    end else if (state_q == CALC) begin
      p_q   <= p_nx;
      cnt_q <= cnt_q + 1'b1;
    end else if (state_q == FIX) begin
      result <= fix_res;
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq (XLEN=64): stimulus pushes expected
// result and latency, a negedge monitor pops on every done pulse.
module tb_muldiv_seq;
  localparam int XLEN = 64;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic            clk, rst, start, busy, done;
  logic [2:0]      op;
  logic [XLEN-1:0] a, b, result;

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [XLEN-1:0] res;
    int              acc;
    int              lat;
    string           name;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  logic [XLEN-1:0] last_res = '0;

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_result"}, result, e.res);
        chk({e.name, "_latency"}, 64'(cyc - e.acc + 1), 64'(e.lat));
      end
    end
  end

  // Called at a negedge; returns at the negedge where done is visible, so
  // consecutive calls exercise back-to-back acceptance in DONE.
  task automatic run(input logic [2:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                     input logic [XLEN-1:0] r, input bit eo, input bit noise, input string nm);
    exp_t e;
    int   k, bc;
    op = o; a = x; b = y; start = 1'b1;
    e.res = r; e.acc = cyc + 1; e.lat = (EARLY && eo) ? 2 : XLEN + 2; e.name = nm;
    sb.push_back(e);
    last_res = r;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, "_accept_busy"}, 64'(busy), 64'd1);
    bc = 0; k = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (busy) bc++;
      k++;
      if (k > 300) begin
        checks++; errors++;
        $display("FAIL %s_timeout: no done after %0d cycles", nm, k);
        break;
      end
      if (noise) begin
        start = (k == 10) || (k == 40);
        op = 3'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
      end
    end
    start = 1'b0;
    chk({nm, "_busy_cycles"}, 64'(bc), 64'(e.lat - 1));
  endtask

  task automatic idle(input int n, input string nm);
    int seen = 0;
    start = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk({nm, "_hold_result"}, result, last_res);
    chk({nm, "_no_done"}, 64'(seen), 64'd0);
  endtask

  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [XLEN-1:0] MNEG = 64'h8000_0000_0000_0000;

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_result", result, '0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // multiply
    run(3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b0, "mul_7x-3");
    run(3'b011, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, "mulhu_max");
    run(3'b001, ONES, ONES, 64'h0, 1'b0, 1'b0, "mulh_-1x-1");
    run(3'b010, ONES, 64'd2, ONES, 1'b0, 1'b0, "mulhsu_-1x2");
    // divide
    run(3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, "div_-7/2");
    run(3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 1'b0, 1'b0, "rem_-7/2");
    run(3'b101, 64'd100, 64'd7, 64'd14, 1'b0, 1'b0, "divu_100/7");
    run(3'b111, 64'd100, 64'd7, 64'd2, 1'b0, 1'b0, "remu_100/7");
    idle(5, "after_remu");
    // special cases (early-out candidates)
    run(3'b101, 64'h1234, 64'd0, ONES, 1'b1, 1'b0, "divu_by0");
    run(3'b110, 64'h1234, 64'd0, 64'h1234, 1'b1, 1'b0, "rem_by0");
    run(3'b100, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, ONES, 1'b1, 1'b0, "div_-5by0");
    run(3'b111, 64'hDEAD, 64'd0, 64'hDEAD, 1'b1, 1'b0, "remu_by0");
    run(3'b100, MNEG, ONES, MNEG, 1'b1, 1'b0, "div_ovf");
    run(3'b110, MNEG, ONES, 64'h0, 1'b1, 1'b0, "rem_ovf");
    run(3'b000, 64'd0, 64'h55, 64'h0, 1'b1, 1'b0, "mul_zero");
    run(3'b100, MNEG, 64'd2, 64'hC000_0000_0000_0000, 1'b0, 1'b0, "div_mneg/2");
    idle(3, "after_special");
    // ignored starts while busy, then back-to-back from DONE
    run(3'b000, 64'd3, 64'd5, 64'd15, 1'b0, 1'b1, "mul_3x5_noise");
    run(3'b011, 64'd3, 64'd5, 64'd0, 1'b0, 1'b0, "mulhu_b2b");
    run(3'b101, 64'd15, 64'd4, 64'd3, 1'b0, 1'b0, "divu_b2b");
    idle(4, "after_b2b");

    // reset in the middle of CALC
    op = 3'b000; a = 64'd9; b = 64'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_result", result, '0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("midrst_no_done", 64'(seen), 64'd0);
    run(3'b000, 64'd6, 64'd7, 64'd42, 1'b0, 1'b0, "mul_after_rst");
    idle(3, "final");
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
